// File: rtl/mfp_ahb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_interconnect
// Purpose  : AHB-lite decoder, read-data mux and response combiner for
//            N slaves with a built-in default (ERROR) slave.
// Options  : MFP_AHB_TIMEOUT_EN enables the slave wait-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_ahb_interconnect #(
  parameter int                      N_SLAVES       = 4,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE       = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK       = {N_SLAVES{32'h0}},
  parameter int                      TIMEOUT_CYCLES = 256
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  output logic [N_SLAVES-1:0]      HSEL,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [31:0]              HRDATA,
  input  logic [N_SLAVES-1:0]      HREADYOUT_S,
  input  logic [N_SLAVES-1:0]      HRESP_S,
  input  logic [N_SLAVES*32-1:0]   HRDATA_S
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t           r_ds_state;
  ds_state_t           w_ds_next;
  logic [N_SLAVES-1:0] w_match;
  logic [N_SLAVES-1:0] r_dp_sel;
  logic                r_dp_def;
  logic                w_hit;
  logic                w_unmapped_req;
  logic                w_timeout;
  logic                w_unused;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_match
    assign w_match[i] = ((HADDR & SLV_MASK[32*i +: 32]) ==
                         (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]));
  end

  assign w_hit          = |w_match;
  assign w_unmapped_req = HTRANS[1] && !w_hit;

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    HSEL = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        HSEL    = '0;
        HSEL[i] = 1'b1;
      end
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (r_ds_state)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DS_ERR2: begin
        HRESP  = 1'b1;
      end
      default: begin
        if (!r_dp_def) begin
          for (int i = 0; i < N_SLAVES; i++) begin
            if (r_dp_sel[i]) begin
              HREADY = HREADYOUT_S[i];
              HRESP  = HRESP_S[i];
              HRDATA = HRDATA_S[32*i +: 32];
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    w_ds_next = r_ds_state;
    case (r_ds_state)
      DS_IDLE: if ((HREADY && w_unmapped_req) || w_timeout) w_ds_next = DS_ERR1;
      DS_ERR1: w_ds_next = DS_ERR2;
      DS_ERR2: w_ds_next = w_unmapped_req ? DS_ERR1 : DS_IDLE;
      default: w_ds_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ds_state <= DS_IDLE;
      r_dp_sel   <= '0;
      r_dp_def   <= 1'b0;
    end else begin
      r_ds_state <= w_ds_next;
      if (HREADY) begin
        r_dp_sel <= HSEL;
        r_dp_def <= w_unmapped_req;
      end else if (w_timeout) begin
        r_dp_sel <= '0;
      end
    end
  end

`ifdef MFP_AHB_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_cnt_w-1:0] r_to_cnt;
  logic               w_stall;

  assign w_stall   = (r_ds_state == DS_IDLE) && (|r_dp_sel) && !(|(HREADYOUT_S & r_dp_sel));
  assign w_timeout = w_stall && (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
  assign w_unused  = ^{HWRITE, HTRANS[0]};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_to_cnt <= '0;
    end else if (HREADY || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + c_cnt_w'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{HWRITE, HTRANS[0], (TIMEOUT_CYCLES > 1)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_ahb_interconnect
// Purpose  : Scoreboard bench for mfp_ahb_interconnect with behavioural slaves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_interconnect;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [NS*32-1:0] P_BASE = {32'h1F000000, 32'h1F800000, 32'h00000000, 32'h1FC00000};
  localparam logic [NS*32-1:0] P_MASK = {32'h1F000000, 32'h1FF00000, 32'h10000000, 32'h1FC00000};

  logic [31:0] m_base [NS] = '{32'h1FC00000, 32'h00000000, 32'h1F800000, 32'h1F000000};
  logic [31:0] m_mask [NS] = '{32'h1FC00000, 32'h10000000, 32'h1FF00000, 32'h1F000000};

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic [31:0]      HADDR = '0;
  logic [1:0]       HTRANS = T_IDLE;
  logic             HWRITE = 1'b0;
  logic [NS-1:0]    HSEL;
  logic             HREADY;
  logic             HRESP;
  logic [31:0]      HRDATA;
  logic [NS-1:0]    HREADYOUT_S = '1;
  logic [NS-1:0]    HRESP_S = '0;
  logic [NS*32-1:0] HRDATA_S = '0;

  mfp_ahb_interconnect #(
    .N_SLAVES       (NS),
    .SLV_BASE       (P_BASE),
    .SLV_MASK       (P_MASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSEL        (HSEL),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S)
  );

  always #5 HCLK = ~HCLK;

  // One entry per data phase: low cycles before completion, the low cycle at
  // which HRESP rises (w+1 = never during the wait), final response and data.
  typedef struct {
    int          w;
    int          err_at;
    logic        resp;
    logic [31:0] d;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;
  int   lowcnt = 0;

  // Reference view of the current data phase
  int          cur_slv = -1;
  int          cur_wl  = 0;
  int          cur_st  = 0;
  int          cur_ep  = 0;
  logic [31:0] cur_d   = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  function automatic bit model_ready();
    if (cur_ep == 1) return 1'b0;
    if (cur_slv >= 0) return (cur_wl == 0);
    return 1'b1;
  endfunction

  task automatic drive_slaves();
    for (int i = 0; i < NS; i++) begin
      HREADYOUT_S[i]       = 1'($urandom_range(0, 1));
      HRESP_S[i]           = 1'($urandom_range(0, 1));
      HRDATA_S[32*i +: 32] = $urandom;
    end
    if (cur_slv >= 0) begin
      HREADYOUT_S[cur_slv] = (cur_wl == 0);
      HRESP_S[cur_slv]     = 1'b0;
      if (cur_wl == 0) HRDATA_S[32*cur_slv +: 32] = cur_d;
    end
  endtask

  task automatic advance();
    if (cur_ep == 1) begin
      cur_ep = 2;
    end else if (cur_slv >= 0 && cur_wl > 0) begin
      cur_st++;
      cur_wl--;
`ifdef MFP_AHB_TIMEOUT_EN
      if (cur_st == TO) begin
        cur_slv = -1;
        cur_ep  = 1;
        cur_wl  = 0;
      end
`endif
    end
  endtask

  // Present one address phase, hold it until the model says it is taken.
  task automatic xfer(input logic [31:0] a, input logic [1:0] t, input int w, input logic [31:0] d);
    exp_t e;
    int   s;
    bit   rdy;
    HADDR  = a;
    HTRANS = t;
    HWRITE = 1'($urandom_range(0, 1));
    drive_slaves();
    while (1) begin
      rdy = model_ready();
      @(posedge HCLK); #1;
      if (rdy) break;
      advance();
      drive_slaves();
    end
    s = decode(a);
    cur_slv = -1; cur_wl = 0; cur_st = 0; cur_ep = 0; cur_d = '0;
    if (s >= 0) begin
      cur_slv  = s;
      cur_wl   = t[1] ? w : 0;
      cur_d    = d;
      e.w      = cur_wl;
      e.err_at = cur_wl + 1;
      e.resp   = 1'b0;
      e.d      = d;
`ifdef MFP_AHB_TIMEOUT_EN
      if (cur_wl >= TO) begin
        e.w = TO + 1; e.err_at = TO + 1; e.resp = 1'b1; e.d = '0;
      end
`endif
    end else if (t[1]) begin
      cur_ep = 1;
      e.w = 1; e.err_at = 1; e.resp = 1'b1; e.d = '0;
    end else begin
      e.w = 0; e.err_at = 1; e.resp = 1'b0; e.d = '0;
    end
    sb.push_back(e);
    drive_slaves();
  endtask

  // Monitor
  initial begin
    exp_t          e;
    logic [NS-1:0] eh;
    int            s;
    forever begin
      @(negedge HCLK);
      s  = decode(HADDR);
      eh = '0;
      if (s >= 0) eh[s] = 1'b1;
      chk("hsel", 32'(HSEL), 32'(eh));
      if (HRESET || sb.size() == 0) begin
        chk("idle_hready", 32'(HREADY), 32'd1);
        chk("idle_hresp", 32'(HRESP), 32'd0);
        chk("idle_hrdata", HRDATA, 32'd0);
      end else begin
        e = sb[0];
        chk("hready", 32'(HREADY), 32'(lowcnt == e.w));
        if (HREADY) begin
          chk("hresp", 32'(HRESP), 32'(e.resp));
          chk("hrdata", HRDATA, e.d);
          void'(sb.pop_front());
          lowcnt = 0;
        end else begin
          lowcnt++;
          chk("hresp_wait", 32'(HRESP), 32'(lowcnt >= e.err_at));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  tr;
    drive_slaves();
    repeat (3) @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    xfer(32'hBFC00010, T_NONSEQ, 0, 32'hCAFE0001);
    xfer(32'h80000004, T_NONSEQ, 3, 32'h11110004);
    xfer(32'h1E000000, T_NONSEQ, 0, 32'h0);
    xfer(32'h1E000000, T_IDLE,   0, 32'h0);
    xfer(32'h1E000004, T_NONSEQ, 0, 32'h0);
    xfer(32'hBFC00020, T_NONSEQ, 0, 32'hCAFE0020);
    xfer(32'h1E000008, T_NONSEQ, 0, 32'h0);
    xfer(32'h1E00000C, T_SEQ,    0, 32'h0);
    xfer(32'h1F800100, T_NONSEQ, 1, 32'h22220100);
    xfer(32'h1F000040, T_NONSEQ, 2, 32'h33330040);

    // Asynchronous reset in the middle of a slave wait state
    xfer(32'h80000008, T_NONSEQ, 3, 32'h5A5A0008);
    HADDR  = 32'hBFC00040;
    HTRANS = T_NONSEQ;
    drive_slaves();
    @(posedge HCLK); #1;
    advance();
    drive_slaves();
    #2 HRESET = 1'b1;
    #1;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    sb.delete();
    lowcnt = 0;
    cur_slv = -1; cur_wl = 0; cur_st = 0; cur_ep = 0;
    HTRANS = T_IDLE;
    drive_slaves();
    @(posedge HCLK); #1;
    HRESET = 1'b0;

`ifdef MFP_AHB_TIMEOUT_EN
    xfer(32'h80000010, T_NONSEQ, 1000, 32'h44440010);
    xfer(32'hBFC00030, T_NONSEQ, 0, 32'hCAFE0030);
`endif

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h1FC00000 | ($urandom & 32'h003FFFFC) | (($urandom_range(0, 1) != 0) ? 32'hA0000000 : 32'h0);
        1: a = $urandom & 32'hEFFFFFFC;
        2: a = 32'h1F800000 | ($urandom & 32'h000FFFFC);
        3: a = 32'h1F000000 | ($urandom & 32'h007FFFFC);
        4: a = 32'h10000000 | ($urandom & 32'h0EFFFFFC);
        default: a = $urandom;
      endcase
      tr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) tr[1] = 1'b1;
      xfer(a, tr, $urandom_range(0, 3), $urandom);
    end

    xfer(32'h10000000, T_IDLE, 0, 32'h0);
    repeat (3) @(negedge HCLK);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mfp_ahb_interconnect.md
Name: mfp_ahb_interconnect

Overview:
- Parametrised AHB-lite address decoder, read-data mux and response combiner for N memory-mapped slaves (boot RAM, program RAM, GPIO, seven-segment, future peripherals).
- Adds three things over the fixed 4-slave decoder:
  - slave wait-state propagation (per-slave HREADYOUT);
  - a built-in default slave that returns a two-cycle AHB ERROR for unmapped addresses;
  - registered data-phase tracking that advances only on HREADY.
- Sits between the MIPS core's AHB-lite master port and all slaves.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- SLV_BASE, {N_SLAVES{32'h0}}, packed N_SLAVES*32 base addresses; slave i = bits [32i+31:32i].
- SLV_MASK, {N_SLAVES{32'h0}}, packed N_SLAVES*32 compare masks; slave i matches when (HADDR & MASK_i) == (BASE_i & MASK_i).
- TIMEOUT_CYCLES, 256, wait-state limit used only with MFP_AHB_TIMEOUT_EN (must be >= 2).

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous reset, active high.
- HADDR  in  32  master address (address phase).
- HTRANS  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HWRITE  in  1  master write flag (passed through, unused internally).
- HSEL  out  N_SLAVES  one-hot combinational slave select.
- HREADY  out  1  combined ready to master; also fed back to all slaves.
- HRESP  out  1  combined response to master (0 OKAY, 1 ERROR).
- HRDATA  out  32  combined read data to master.
- HREADYOUT_S  in  N_SLAVES  per-slave ready.
- HRESP_S  in  N_SLAVES  per-slave response.
- HRDATA_S  in  N_SLAVES*32  packed per-slave read data.

Behaviour:
- Decode (combinational, not gated by HTRANS):
  - match_i per mask/base rule above; overlapping matches resolve to the lowest index.
  - HSEL is one-hot or all-zero.
  - addr_hit = |match.
- Data-phase register, updated only on posedge HCLK with HREADY=1:
  - dp_sel <= one-hot HSEL.
  - dp_def <= (HTRANS[1] & ~addr_hit), i.e. the default slave owns the data phase.
  - When HREADY=0 both hold.
- Reset (async, HRESET=1):
  - dp_sel=0, dp_def=0, default-slave FSM=DS_IDLE, timeout counter=0.
  - Outputs during and after reset until the first transfer: HREADY=1, HRESP=0, HRDATA=32'h0.
- Output mux:
  - dp_sel bit i set: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=slice i.
  - dp_sel=0 and DS_IDLE: HREADY=1, HRESP=0, HRDATA=0. IDLE/BUSY to an unmapped address completes zero-wait OKAY.
- Default-slave FSM (DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE -> DS_ERR1 on the clock edge where HREADY=1, HTRANS[1]=1 and addr_hit=0.
  - DS_ERR1: HREADY=0, HRESP=1; always -> DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1; HRDATA=0.
    - Exits to DS_ERR1 if a new NONSEQ/SEQ unmapped transfer is in its address phase; otherwise to DS_IDLE.
    - A mapped transfer presented in DS_ERR2 is accepted normally and dp_sel captures it.
- Latency:
  - Mapped transfer: data phase one cycle after address phase, plus slave wait states.
  - Unmapped transfer: exactly 2 data-phase cycles.
- Back-to-back transfers to different slaves are pipelined with no bubble.
- Reset asserted mid-transfer abandons the transfer; the first cycle after release is idle/OKAY.

Optional Feature:
- Macro: MFP_AHB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle a mapped data phase is active with HREADYOUT_S[dp_sel]=0.
  - It clears whenever HREADY=1.
  - When it reaches TIMEOUT_CYCLES-1, the interconnect overrides the stuck slave and forces the DS_ERR1/DS_ERR2 two-cycle ERROR (HREADY 0/1, HRESP 1/1), then clears dp_sel.
  - The stuck slave sees HREADY=1 in DS_ERR2 and is thereby released.
- Undefined: no counter; a slave may stall indefinitely; TIMEOUT_CYCLES is ignored.

Test Plan:
- Config BASE0=1FC00000/MASK0=1FC00000, BASE1=0/MASK1=10000000. NONSEQ read 0xBFC00010 with slave0 data 32'hCAFE0001 -> HSEL=4'b0001 same cycle; HRDATA=CAFE0001, HREADY=1, HRESP=0 next cycle.
- Slave1 HREADYOUT low for 3 cycles on read 0x80000004 -> HREADY low exactly 3 cycles; next address held; dp_sel unchanged; completes with slave1 data.
- NONSEQ to unmapped 0x1E000000 -> HSEL=0; data phase gives HREADY=0/HRESP=1 then HREADY=1/HRESP=1; HRDATA=0. Same address with HTRANS=IDLE -> single-cycle OKAY.
- Back-to-back: unmapped NONSEQ followed immediately by mapped read -> ERROR pair, then mapped data on the next cycle; no extra idle cycle.
- HRESET pulsed during slave wait state -> HREADY=1, HRESP=0, HRDATA=0 immediately (async); FSM DS_IDLE.
- With MFP_AHB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave holds HREADYOUT=0 forever -> after 8 stalled cycles, ERROR pair on HRESP; the bus then accepts the next transfer.
